// File: rtl/dec_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the decoder scan sequencer.
// The controller owns start/stop/mode/mask/dwell; the sequencer owns en/w/busy/done.
interface dec_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [15:0]        mask;
  logic [DWELL_W-1:0] dwell;
  logic               en;
  logic [3:0]         w;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, mask, dwell,
    input  en, w, busy, done
  );

  modport slave (
    input  start, stop, mode, mask, dwell,
    output en, w, busy, done
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Steps a 4-to-16 decoder through the set bits of a latched mask, holding each
// selection for a dwell time with a one-cycle blank between selections.
module dec_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  dec_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_reg;
  logic [15:0]        mask_reg;
  logic               mode_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [3:0]         w_reg;
  logic               en_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [3:0]         first_idx;
  logic [15:0]        above_mask;
  logic [3:0]         above_idx;
  logic [3:0]         wrap_idx;
  logic [3:0]         next_idx;
  logic               next_valid;
  logic [DWELL_W-1:0] start_dwell;

  // A dwell of zero still produces one enabled cycle.
  assign start_dwell = (bus.dwell == '0) ? DWELL_ONE : bus.dwell;

  always_comb begin
    first_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (bus.mask[i]) first_idx = 4'(i);
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_above
    assign above_mask[gi] = mask_reg[gi] && (4'(gi) > w_reg);
  end

  // Latched mask is never zero while busy, so wrap_idx is always a real bit.
  always_comb begin
    above_idx = '0;
    wrap_idx  = '0;
    for (int i = 15; i >= 0; i--) begin
      if (above_mask[i]) above_idx = 4'(i);
      if (mask_reg[i])   wrap_idx  = 4'(i);
    end
    next_valid = (above_mask != '0) || mode_reg;
    next_idx   = (above_mask != '0) ? above_idx : wrap_idx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      mode_reg  <= 1'b0;
      dwell_reg <= '0;
      cnt_reg   <= '0;
      w_reg     <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.stop && (bus.mask != '0)) begin
            mask_reg  <= bus.mask;
            mode_reg  <= bus.mode;
            dwell_reg <= start_dwell;
            cnt_reg   <= start_dwell;
            w_reg     <= first_idx;
            en_reg    <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_reg <= DWELL_ONE) begin
            en_reg <= 1'b0;
            if (next_valid) begin
              state_reg <= BLANK;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - DWELL_ONE;
          end
        end
        BLANK: begin
          if (bus.stop) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            w_reg     <= next_idx;
            cnt_reg   <= dwell_reg;
            en_reg    <= 1'b1;
            state_reg <= SCAN;
          end
        end
        default: begin
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.en   = en_reg;
  assign bus.w    = w_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Scoreboard bench for dec_scan_sequencer: expected selections are queued at
// stimulus time and popped on every enabled cycle.
module tb_dec_scan_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_q[$];

  dec_scan_sequencer_if #(.DWELL_W(8)) bus ();

  dec_scan_sequencer #(.DWELL_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic push_sweep(input logic [15:0] m, input int d, input int passes);
    int dd = (d == 0) ? 1 : d;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 16; i++)
        if (m[i])
          for (int k = 0; k < dd; k++) exp_q.push_back(4'(i));
  endtask

  task automatic start_scan(input logic [15:0] m, input logic [7:0] d, input logic md);
    @(negedge clk);
    bus.mask  = m;
    bus.dwell = d;
    bus.mode  = md;
    bus.start = 1'b1;
  endtask

  // Watches outputs each cycle; poke_cycle re-issues start with a new mask mid-scan.
  task automatic run_monitor(input string name, input int exp_busy, input bit expect_done,
                             input bit stop_at_empty, input int poke_cycle);
    int c = 0;
    int busy_n = 0;
    bit seen_done = 1'b0;
    bit prev_en = 1'b0;
    logic [3:0] prev_w = '0;
    logic [3:0] got;
    while (c < 400 && !seen_done) begin
      @(negedge clk);
      bus.start = 1'b0;
      c++;
      if (c == poke_cycle) begin
        bus.mask  = 16'h0001;
        bus.start = 1'b1;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra_sel: cycle %0d w=%0d, required no selection", name, c, bus.w);
        end else begin
          got = exp_q.pop_front();
          if (bus.w !== got) begin
            n_bad++;
            $display("FAIL %s sel_w: cycle %0d w=%0d, required %0d", name, c, bus.w, got);
          end
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s en_with_done: cycle %0d done=%b, required 0", name, c, bus.done);
        end
        if (prev_en) begin
          n_cmp++;
          if (bus.w !== prev_w) begin
            n_bad++;
            $display("FAIL %s no_blank: cycle %0d w=%0d after w=%0d, required a blank", name, c, bus.w, prev_w);
          end
        end
      end
      prev_en = (bus.en === 1'b1);
      prev_w  = bus.w;
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        n_cmp++;
        if (!expect_done) begin
          n_bad++;
          $display("FAIL %s unexpected_done: cycle %0d done=1, required 0", name, c);
        end else begin
          if (c != exp_busy + 1) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d, required %0d", name, c, exp_busy + 1);
          end
          n_cmp++;
          if (busy_n != exp_busy) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_n, exp_busy);
          end
          n_cmp++;
          if ({bus.en, bus.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s done_state: en,busy=%b, required 00", name, {bus.en, bus.busy});
          end
          @(negedge clk);
          n_cmp++;
          if ({bus.done, bus.busy, bus.en} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s done_pulse: done,busy,en=%b, required 000", name, {bus.done, bus.busy, bus.en});
          end
        end
      end
      if (stop_at_empty && exp_q.size() == 0 && bus.en === 1'b1) begin
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        n_cmp++;
        if ({bus.en, bus.busy, bus.done} !== 3'b000) begin
          n_bad++;
          $display("FAIL %s stop_idle: en,busy,done=%b, required 000", name, {bus.en, bus.busy, bus.done});
        end
        repeat (4) begin
          @(negedge clk);
          n_cmp++;
          if ({bus.en, bus.busy, bus.done} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s after_stop: en,busy,done=%b, required 000", name, {bus.en, bus.busy, bus.done});
          end
        end
        break;
      end
    end
    if (expect_done && !seen_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: done not seen in %0d cycles, required done", name, c);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s leftover: %0d selections missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      n_cmp++;
      if ({bus.en, bus.busy, bus.done} !== 3'b000) begin
        n_bad++;
        $display("FAIL %s idle: en,busy,done=%b, required 000", name, {bus.en, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.en, bus.busy, bus.done, bus.w} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state: en,busy,done,w=%b, required 0000000", {bus.en, bus.busy, bus.done, bus.w});
    end
    resetn = 1'b1;
    check_idle("reset_release", 2);
  endtask

  task automatic test_single_bit();
    push_sweep(16'h0001, 3, 1);
    start_scan(16'h0001, 8'd3, 1'b0);
    run_monitor("single_bit", 3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_sweep();
    push_sweep(16'h8421, 2, 1);
    start_scan(16'h8421, 8'd2, 1'b0);
    run_monitor("sweep_8421", 11, 1'b1, 1'b0, -1);
  endtask

  task automatic test_continuous_stop();
    push_sweep(16'h000A, 0, 2);
    start_scan(16'h000A, 8'd0, 1'b1);
    run_monitor("cont_stop", 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_ignored_start();
    start_scan(16'h0000, 8'd5, 1'b0);
    check_idle("zero_mask", 5);
    @(negedge clk);
    bus.mask  = 16'hFFFF;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    check_idle("start_stop", 5);
  endtask

  task automatic test_back_to_back();
    push_sweep(16'hFFFF, 4, 1);
    start_scan(16'hFFFF, 8'd4, 1'b0);
    run_monitor("restart_busy", 79, 1'b1, 1'b0, 20);
  endtask

  task automatic test_async_reset();
    start_scan(16'h0080, 8'd4, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.en, bus.w} !== 5'b1_0111) begin
      n_bad++;
      $display("FAIL async_pre: en,w=%b, required 10111", {bus.en, bus.w});
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.en, bus.busy, bus.done, bus.w} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_reset: en,busy,done,w=%b, required 0000000", {bus.en, bus.busy, bus.done, bus.w});
    end
    @(negedge clk);
    resetn = 1'b1;
    check_idle("post_reset", 4);
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_sweep();
    test_continuous_stop();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_scan_sequencer.md
Name: dec_scan_sequencer

Overview:
Sequential address/enable generator that drives the 4-to-16 one-hot decoder stage (its en and w[3:0] inputs). It steps through a programmable set of the 16 decoder outputs, holding each one for a programmable dwell time. A one-cycle blank (en low) separates consecutive selections, so two decoder outputs are never active in the same cycle. It is used for row/strobe scanning, either as a single sweep or continuously.

Parameters:
DWELL_W, 8, width of the dwell-time input and the internal dwell counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  level sampled each cycle; begins a scan when the block is idle.
stop  input  1  level sampled each cycle; aborts the scan in progress.
mode  input  1  0 = single sweep, 1 = continuous (wrap-around); latched at start.
mask  input  16  bit i = 1 means output i is visited; latched at start.
dwell  input  DWELL_W  cycles en stays high per selection; 0 is treated as 1; latched at start.
en  output  1  decoder enable.
w  output  4  decoder select index.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse on normal completion of a single sweep.

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE, en = 0, w = 0, busy = 0, done = 0, all latched registers and counters = 0.
- States:
  - IDLE: en = 0, w holds its last value.
  - SCAN: en = 1, w = current index.
  - BLANK: en = 0, w holds the current index.
- IDLE -> SCAN:
  - Condition: start = 1, stop = 0 and mask != 0, sampled at an edge.
  - On that edge: mask, mode and dwell are latched; w = lowest set mask bit; en = 1; busy = 1; dwell counter = max(dwell, 1).
  - Latency from the start edge to en high is one cycle.
- start with mask = 0: ignored. Block stays IDLE, no done pulse.
- SCAN:
  - The counter decrements each cycle; en stays high for exactly max(dwell, 1) cycles.
  - On the last cycle, if a next index exists: -> BLANK.
  - Next index = lowest set latched-mask bit strictly above w. In continuous mode, if there is none, wrap to the lowest set bit.
  - If no next index exists (single mode, highest set bit just finished): -> IDLE with done = 1 for one cycle, busy = 0, en = 0.
- BLANK:
  - Lasts exactly 1 cycle with en = 0.
  - Then -> SCAN with w = next index and the counter reloaded to max(latched dwell, 1).
- Single set bit:
  - Single mode: one dwell, then done.
  - Continuous mode: SCAN and BLANK alternate on the same index.
- stop = 1 in SCAN or BLANK: next edge -> IDLE, en = 0, busy = 0, no done pulse. stop has priority over any transition on the same edge.
- start and stop both high in IDLE: stop wins; the block stays IDLE.
- start while busy: ignored. Changes to mask, dwell or mode while busy have no effect until the next start.
- done and en are never high in the same cycle. en is never high for two different w values in consecutive cycles.
- Asynchronous reset mid-scan: en drops immediately (asynchronously) and all outputs return to their reset values.

Test Plan:
1. Reset, then mask = 16'h0001, dwell = 3, mode = 0, start pulse -> en high 3 cycles with w = 0; busy high; then done = 1 for one cycle; en = 0; busy = 0.
2. mask = 16'h8421, dwell = 2, mode = 0 -> w sequence 0, 5, 10, 15; each has en high 2 cycles followed by 1 blank cycle (none after 15); done in the cycle after the last en-high cycle; total busy = 11 cycles.
3. mask = 16'h000A, dwell = 0, mode = 1 -> en high 1 cycle per selection; w alternates 1, 3, 1, 3 with blanks between; stop asserted during w = 3 -> en = 0 and busy = 0 on the next edge; no done pulse.
4. mask = 16'h0000 with start -> busy stays 0, en stays 0, no done pulse. start and stop asserted together with mask = 16'hFFFF -> block stays IDLE.
5. Mid-sweep (mask = 16'hFFFF, dwell = 4), change mask to 16'h0001 and pulse start again -> sequence continues 0, 1, 2 … 15 unchanged; done after w = 15.
6. Assert resetn low while en = 1, w = 7 -> en, busy and w go to 0 without waiting for a clock edge; after release the block stays IDLE until start.
